// File: rtl/fft_peak_detect.sv
// Streaming peak-power detector for a two-lane natural-order FFT output; reports the strongest bin per frame.
// Optional FFT_PEAK_POSITIVE_ONLY_EN restricts the search to bins 1..N/2-1.
module fft_peak_detect #(
  parameter int OWIDTH = 19,
  parameter int LGSIZE = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*OWIDTH-1:0]   i_left,
  input  logic [2*OWIDTH-1:0]   i_right,
  input  logic                  i_sync,
  output logic                  o_valid,
  output logic [LGSIZE-1:0]     o_peak_bin,
  output logic [2*OWIDTH-1:0]   o_peak_pwr,
  output logic                  o_err,
  output logic                  state_dbg
);

  // Handshake: no backpressure; a pair is consumed on every i_ce=1 cycle, o_valid/o_err are single-cycle pulses.
  localparam int PW = 2 * OWIDTH;
  localparam int CW = LGSIZE - 1;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;

  logic [CW-1:0]     cnt;
  logic              s1_v, s1_first, s1_last;
  logic [CW-1:0]     s1_pair;
  logic [PW-1:0]     sq_l, sq_r;
  logic [PW-1:0]     best_pwr;
  logic [LGSIZE-1:0] best_bin;
  logic              s2_last, pend;

  logic [PW-1:0]     base_pwr, mid_pwr, nxt_pwr;
  logic [LGSIZE-1:0] base_bin, mid_bin, nxt_bin, first_bin;
  logic              elig_l, elig_r;

  function automatic logic [PW-1:0] power(input logic [PW-1:0] s);
    logic signed [OWIDTH-1:0] re, im;
    logic signed [PW-1:0]     xr, xi, rr, ii;
    re = s[PW-1:OWIDTH];
    im = s[OWIDTH-1:0];
    xr = {{OWIDTH{re[OWIDTH-1]}}, re};
    xi = {{OWIDTH{im[OWIDTH-1]}}, im};
    rr = xr * xr;
    ii = xi * xi;
    return $unsigned(rr) + $unsigned(ii);
  endfunction

`ifdef FFT_PEAK_POSITIVE_ONLY_EN
  assign first_bin = LGSIZE'(1);
  assign elig_l    = !s1_pair[CW-1] && (s1_pair != '0);
  assign elig_r    = !s1_pair[CW-1];
`else
  assign first_bin = '0;
  assign elig_l    = 1'b1;
  assign elig_r    = 1'b1;
`endif

  // Left is tested before right so equal powers keep the lower bin.
  always_comb begin
    base_pwr = s1_first ? '0 : best_pwr;
    base_bin = s1_first ? first_bin : best_bin;
    mid_pwr  = base_pwr;
    mid_bin  = base_bin;
    if (elig_l && (sq_l > base_pwr)) begin
      mid_pwr = sq_l;
      mid_bin = {s1_pair, 1'b0};
    end
    nxt_pwr = mid_pwr;
    nxt_bin = mid_bin;
    if (elig_r && (sq_r > mid_pwr)) begin
      nxt_pwr = sq_r;
      nxt_bin = {s1_pair, 1'b1};
    end
  end

  assign state_dbg = logic'(state);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      s1_v       <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_pair    <= '0;
      sq_l       <= '0;
      sq_r       <= '0;
      best_pwr   <= '0;
      best_bin   <= '0;
      s2_last    <= 1'b0;
      pend       <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_peak_bin <= '0;
      o_peak_pwr <= '0;
    end else begin
      o_err   <= 1'b0;
      pend    <= 1'b0;
      o_valid <= pend;
      if (i_ce) begin
        s1_v     <= 1'b0;
        s1_first <= 1'b0;
        s1_last  <= 1'b0;
        sq_l     <= power(i_left);
        sq_r     <= power(i_right);
        case (state)
          IDLE: begin
            if (i_sync) begin
              state    <= ACCUM;
              cnt      <= '0;
              s1_v     <= 1'b1;
              s1_first <= 1'b1;
              s1_pair  <= '0;
            end
          end
          ACCUM: begin
            if (i_sync) begin
              // Early sync: the new pair restarts the frame; the partial result is overwritten.
              o_err    <= 1'b1;
              cnt      <= '0;
              s1_v     <= 1'b1;
              s1_first <= 1'b1;
              s1_pair  <= '0;
            end else begin
              cnt     <= cnt + 1'b1;
              s1_v    <= 1'b1;
              s1_pair <= cnt + 1'b1;
              if (cnt + 1'b1 == '1) begin
                s1_last <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
        if (s1_v) begin
          best_pwr <= nxt_pwr;
          best_bin <= nxt_bin;
        end
        s2_last <= s1_v && s1_last;
        pend    <= s2_last;
        if (s2_last) begin
          o_peak_bin <= best_bin;
          o_peak_pwr <= best_pwr;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomised and directed frames against a bin-by-bin reference search; monitor pops expected results on o_valid.
module tb_fft_peak_detect;
  localparam int OW = 19;
  localparam int LG = 12;
  localparam int N  = 4096;
  localparam int NP = 2048;
  localparam int PW = 2 * OW;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ce = 1'b0;
  logic [PW-1:0] i_left = '0;
  logic [PW-1:0] i_right = '0;
  logic          i_sync = 1'b0;
  logic          o_valid;
  logic [LG-1:0] o_peak_bin;
  logic [PW-1:0] o_peak_pwr;
  logic          o_err;
  logic          state_dbg;

  fft_peak_detect #(.OWIDTH(OW), .LGSIZE(LG)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_left(i_left), .i_right(i_right),
    .i_sync(i_sync), .o_valid(o_valid), .o_peak_bin(o_peak_bin), .o_peak_pwr(o_peak_pwr),
    .o_err(o_err), .state_dbg(state_dbg)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int re_a[N];
  int im_a[N];
  logic [LG+PW-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pack(input int r, input int i);
    logic [31:0] a, b;
    a = r;
    b = i;
    return {a[OW-1:0], b[OW-1:0]};
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < N; k++) begin
      re_a[k] = 0;
      im_a[k] = 0;
    end
  endtask

  // Reference: scan every bin in ascending order, keep the first strictly larger power.
  task automatic push_model();
    longint best, p;
    int bb;
    bit elig;
`ifdef FFT_PEAK_POSITIVE_ONLY_EN
    bb = 1;
`else
    bb = 0;
`endif
    best = 0;
    for (int k = 0; k < N; k++) begin
`ifdef FFT_PEAK_POSITIVE_ONLY_EN
      elig = (k >= 1) && (k < N / 2);
`else
      elig = 1'b1;
`endif
      p = longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k];
      if (elig && p > best) begin
        best = p;
        bb = k;
      end
    end
    exp_q.push_back({LG'(bb), PW'(best)});
  endtask

  task automatic send_frame(input int npairs, input bit gaps);
    for (int p = 0; p < npairs; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          i_ce    = 1'b0;
          i_sync  = 1'($urandom_range(0, 1));
          i_left  = pack(rnd(-1000, 1000), rnd(-1000, 1000));
          i_right = pack(rnd(-1000, 1000), rnd(-1000, 1000));
          cyc();
        end
      end
      i_ce    = 1'b1;
      i_sync  = (p == 0);
      i_left  = pack(re_a[2*p], im_a[2*p]);
      i_right = pack(re_a[2*p+1], im_a[2*p+1]);
      cyc();
    end
    i_ce   = 1'b0;
    i_sync = 1'b0;
    if (npairs == NP) push_model();
  endtask

  task automatic flush(input int n);
    i_ce    = 1'b1;
    i_sync  = 1'b0;
    i_left  = '0;
    i_right = '0;
    repeat (n) cyc();
    i_ce = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_err) err_seen++;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got bin %0d pwr %0d expected no result", o_peak_bin, o_peak_pwr);
        end else begin
          logic [LG+PW-1:0] e;
          e = exp_q.pop_front();
          chk("peak_bin", o_peak_bin, e[LG+PW-1:PW]);
          chk("peak_pwr", o_peak_pwr, e[PW-1:0]);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    i_reset = 1'b0;
    cyc();
    chk("reset_valid", o_valid, 0);
    chk("reset_err", o_err, 0);
    chk("reset_bin", o_peak_bin, 0);
    chk("reset_pwr", o_peak_pwr, 0);
    chk("reset_state", state_dbg, 0);

    // Directed frames sent back to back.
    clear_frame(); re_a[7] = 1000;
    send_frame(NP, 0);
    clear_frame(); re_a[10] = 500; im_a[10] = -500; re_a[20] = 500; im_a[20] = -500;
    send_frame(NP, 0);
    clear_frame(); re_a[4095] = -262144; im_a[4095] = -262144;
    send_frame(NP, 0);
    clear_frame(); re_a[0] = 2000; re_a[5] = 10;
    send_frame(NP, 0);

    // Random frames: full range, then a narrow range that forces many ties.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        if (f == 2) begin
          re_a[k] = rnd(-3, 3);
          im_a[k] = rnd(-3, 3);
        end else begin
          re_a[k] = rnd(-262144, 262143);
          im_a[k] = rnd(-262144, 262143);
        end
      end
      send_frame(NP, 0);
    end
    flush(8);
    drain("drain_main");

    // Early sync aborts the partial frame.
    clear_frame(); re_a[7] = 1000;
    send_frame(100, 0);
    err_exp++;
    send_frame(NP, 0);
    flush(8);
    drain("drain_early");
    chk("err_after_early", err_seen, err_exp);

    // Enable gaps with garbage on the inputs.
    send_frame(NP, 1);
    flush(8);
    drain("drain_gaps");

    // Reset in the middle of a frame.
    send_frame(1000, 0);
    i_reset = 1'b1;
    flush(2);
    i_reset = 1'b0;
    flush(10);
    chk("midreset_valid", o_valid, 0);
    chk("midreset_bin", o_peak_bin, 0);
    chk("midreset_pwr", o_peak_pwr, 0);
    chk("midreset_state", state_dbg, 0);
    send_frame(NP, 0);
    flush(8);
    drain("drain_after_reset");

    chk("err_total", err_seen, err_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
